// File: rtl/varredor_hamming.sv
// ============================================================================
// Module      : varredor_hamming
// Description : Background scrubber for a Hamming(15,11) RAM; reads each word
//               over a req/gnt port, corrects single-bit errors, logs events.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module varredor_hamming #(
  parameter int ADDR_W    = 8,
  parameter int INTERVALO = 1024,
  parameter int CONT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              habilita,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  input  logic [14:0]       mem_rdata,
  output logic              mem_we,
  output logic [14:0]       mem_wdata,
  output logic [CONT_W-1:0] cont_corrigidos,
  output logic [ADDR_W-1:0] ultimo_erro_addr,
  output logic [3:0]        ultima_sindrome,
  output logic              varredura_completa,
  output logic              ocupado
);

  localparam int                 c_INT_W    = (INTERVALO > 1) ? $clog2(INTERVALO) : 1;
  localparam logic [c_INT_W-1:0] c_INT_LOAD = c_INT_W'(INTERVALO - 1);

  typedef enum logic [2:0] {
    S_OCIOSO  = 3'd0,
    S_ESPERA  = 3'd1,
    S_PEDE    = 3'd2,
    S_LE      = 3'd3,
    S_CAPTURA = 3'd4,
    S_CHECA   = 3'd5,
    S_ESCREVE = 3'd6,
    S_LIBERA  = 3'd7
  } estado_t;

  estado_t             r_estado;
  estado_t             w_prox;
  logic [c_INT_W-1:0]  r_intervalo;
  logic [ADDR_W-1:0]   r_addr;
  logic [14:0]         r_word;
  logic [3:0]          w_sind;
  logic [14:0]         w_corrigida;

  // Each mask selects the codeword positions whose index+1 has that parity bit set.
  assign w_sind[0]   = ^(r_word & 15'h5555);
  assign w_sind[1]   = ^(r_word & 15'h6666);
  assign w_sind[2]   = ^(r_word & 15'h7878);
  assign w_sind[3]   = ^(r_word & 15'h7F80);
  assign w_corrigida = r_word ^ (15'd1 << (w_sind - 4'd1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_estado         <= S_OCIOSO;
      r_intervalo      <= '0;
      r_addr           <= '0;
      r_word           <= '0;
      cont_corrigidos  <= '0;
      ultimo_erro_addr <= '0;
      ultima_sindrome  <= '0;
    end else begin
      r_estado <= w_prox;
      if ((r_estado == S_OCIOSO || r_estado == S_LIBERA) && habilita) begin
        r_intervalo <= c_INT_LOAD;
      end else if (r_estado == S_ESPERA && r_intervalo != '0) begin
        r_intervalo <= r_intervalo - 1'b1;
      end
      if (r_estado == S_CAPTURA) begin
        r_word <= mem_rdata;
      end
      if (r_estado == S_ESCREVE) begin
        if (cont_corrigidos != '1) begin
          cont_corrigidos <= cont_corrigidos + 1'b1;
        end
        ultimo_erro_addr <= r_addr;
        ultima_sindrome  <= w_sind;
      end
      if (r_estado == S_LIBERA) begin
        r_addr <= r_addr + 1'b1;
      end
    end
  end

  always_comb begin
    w_prox             = r_estado;
    mem_req            = 1'b0;
    mem_re             = 1'b0;
    mem_we             = 1'b0;
    mem_addr           = '0;
    mem_wdata          = '0;
    varredura_completa = 1'b0;
    ocupado            = 1'b0;
    case (r_estado)
      S_OCIOSO: begin
        if (habilita) w_prox = S_ESPERA;
      end
      S_ESPERA: begin
        ocupado = 1'b1;
        if (!habilita)               w_prox = S_OCIOSO;
        else if (r_intervalo == '0)  w_prox = S_PEDE;
      end
      S_PEDE: begin
        ocupado  = 1'b1;
        mem_req  = 1'b1;
        mem_addr = r_addr;
        if (!habilita)    w_prox = S_OCIOSO;
        else if (mem_gnt) w_prox = S_LE;
      end
      S_LE: begin
        ocupado  = 1'b1;
        mem_req  = 1'b1;
        mem_re   = 1'b1;
        mem_addr = r_addr;
        w_prox   = S_CAPTURA;
      end
      S_CAPTURA: begin
        ocupado  = 1'b1;
        mem_req  = 1'b1;
        mem_addr = r_addr;
        w_prox   = S_CHECA;
      end
      S_CHECA: begin
        ocupado  = 1'b1;
        mem_req  = 1'b1;
        mem_addr = r_addr;
        w_prox   = (w_sind == 4'd0) ? S_LIBERA : S_ESCREVE;
      end
      S_ESCREVE: begin
        ocupado   = 1'b1;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = r_addr;
        mem_wdata = w_corrigida;
        w_prox    = S_LIBERA;
      end
      S_LIBERA: begin
        ocupado            = 1'b1;
        varredura_completa = (r_addr == '1);
        w_prox             = habilita ? S_ESPERA : S_OCIOSO;
      end
      default: w_prox = S_OCIOSO;
    endcase
    // A reset arriving mid-access must squash strobes in that same cycle.
    if (rst) begin
      mem_req            = 1'b0;
      mem_re             = 1'b0;
      mem_we             = 1'b0;
      mem_addr           = '0;
      mem_wdata          = '0;
      varredura_completa = 1'b0;
      ocupado            = 1'b0;
    end
  end

endmodule

`default_nettype wire
